// File: rtl/keypad_entry_fsm.sv
// 4x4 hex keypad scanner/debouncer accumulating typed digits into a number.
// Ports: clock, reset (async high), mode (0 dec/1 hex), clear, row (active-low
// in), col (one-low out), entry_number, key_code, key_valid (1-cycle pulse).
module keypad_entry_fsm #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode,
  input  logic        clear,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] entry_number,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_TICKS);
  localparam logic [35:0]   DEC_MAX   = 36'd99_999_999;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  logic [3:0]    row_m_q, row_s_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [31:0]   entry_q, entry_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          tick;
  logic          one_low;
  logic [1:0]    cur_row;
  logic [3:0]    lut_code;
  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic [35:0]   prod;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign cnt_inc = cnt_q + CW'(1);

  // Exactly one low row bit is a key; anything else is ignored.
  always_comb begin
    one_low = 1'b1;
    cur_row = 2'd0;
    case (row_s_q)
      4'b1110: cur_row = 2'd0;
      4'b1101: cur_row = 2'd1;
      4'b1011: cur_row = 2'd2;
      4'b0111: cur_row = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    lut_code = 4'h0;
    case ({row_idx_q, col_idx_q})
      4'h0: lut_code = 4'h1;
      4'h1: lut_code = 4'h2;
      4'h2: lut_code = 4'h3;
      4'h3: lut_code = 4'hA;
      4'h4: lut_code = 4'h4;
      4'h5: lut_code = 4'h5;
      4'h6: lut_code = 4'h6;
      4'h7: lut_code = 4'hB;
      4'h8: lut_code = 4'h7;
      4'h9: lut_code = 4'h8;
      4'hA: lut_code = 4'h9;
      4'hB: lut_code = 4'hC;
      4'hC: lut_code = 4'h0;
      4'hD: lut_code = 4'hF;
      4'hE: lut_code = 4'hE;
      default: lut_code = 4'hD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    accept    = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (one_low) begin
            row_idx_d = cur_row;
            cnt_d     = CW'(1);
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        // The accept is taken on the clock after the count is reached.
        if (cnt_q >= CNT_DONE) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else if (tick) begin
          if (one_low && cur_row == row_idx_q) begin
            cnt_d = cnt_inc;
          end else begin
            cnt_d     = '0;
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      HELD: begin
        if (tick) begin
          if (row_s_q == 4'hF) begin
            if (cnt_inc >= CNT_DONE) begin
              cnt_d     = '0;
              state_d   = SCAN;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // x10 as x8 + x2, kept at 36 bits so the overflow test sees the carry.
  assign prod = ({4'b0, entry_q} << 3) + ({4'b0, entry_q} << 1)
              + {32'b0, lut_code};

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    valid_d    = accept;
    code_d     = accept ? lut_code : code_q;
    entry_d    = entry_q;
    if (accept) begin
      if (mode) begin
        entry_d = {entry_q[27:0], lut_code};
      end else if (lut_code <= 4'd9) begin
        if (prod <= DEC_MAX) entry_d = prod[31:0];
      end else if (lut_code == 4'hC) begin
        entry_d = '0;
      end
    end
    if (clear) entry_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_m_q    <= 4'hF;
      row_s_q    <= 4'hF;
      tick_cnt_q <= '0;
      state_q    <= SCAN;
      cnt_q      <= '0;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      entry_q    <= '0;
      code_q     <= 4'h0;
      valid_q    <= 1'b0;
    end else begin
      row_m_q    <= row;
      row_s_q    <= row_m_q;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      entry_q    <= entry_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  assign col          = ~(4'b0001 << col_idx_q);
  assign entry_number = entry_q;
  assign key_code     = code_q;
  assign key_valid    = valid_q;

endmodule

// File: tb/tb_keypad_entry_fsm.sv
// Bench for keypad_entry_fsm: keypad matrix model, table of key presses,
// and hand sequences for glitches, multi-key, reset-in-hold, clear race.
module tb_keypad_entry_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mode  = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] entry_number;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] key_mask = '0;
  logic        ovr_en   = 1'b0;
  logic [3:0]  ovr_row  = 4'hF;

  int n_cmp  = 0;
  int n_bad  = 0;
  int pulses = 0;
  int ecount = 0;

  logic [3:0] keymap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef struct {
    bit          clr;
    bit          md;
    logic [3:0]  code;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  keypad_entry_fsm #(
    .SCAN_DIV(4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .clear(clear),
    .row(row),
    .col(col),
    .entry_number(entry_number),
    .key_code(key_code),
    .key_valid(key_valid)
  );

  always #5 clock = ~clock;

  // Passive matrix: a row reads low when a pressed key joins it to a low col.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !col[c]) row[r] = 1'b0;
    if (ovr_en) row = ovr_row;
  end

  always @(posedge clock) ecount++;
  always @(negedge clock) if (key_valid) pulses++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pos_of(input logic [3:0] k, output int r, output int c);
    r = 0;
    c = 0;
    for (int i = 0; i < 16; i++)
      if (keymap[i] == k) begin
        r = i / 4;
        c = i % 4;
      end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    ecount = 0;
  endtask

  task automatic wait_valid(output bit seen, output logic [3:0] code);
    seen = 1'b0;
    code = 4'h0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (key_valid) begin
        seen = 1'b1;
        code = key_code;
      end
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold,
                       output bit seen, output logic [3:0] code,
                       output int np);
    int r, c, p0;
    pos_of(k, r, c);
    p0 = pulses;
    key_mask[r*4+c] = 1'b1;
    wait_valid(seen, code);
    repeat (hold) @(negedge clock);
    key_mask = '0;
    repeat (40) @(negedge clock);
    np = pulses - p0;
  endtask

  task automatic add(input bit clr, input bit md, input logic [3:0] code,
                     input logic [31:0] exp);
    vec_t v;
    v.clr  = clr;
    v.md   = md;
    v.code = code;
    v.exp  = exp;
    vt.push_back(v);
  endtask

  initial begin
    bit         seen;
    logic [3:0] code;
    logic [3:0] c0;
    int         np, p0;

    add(1, 1, 4'h6, 32'h6);
    add(0, 1, 4'hF, 32'h6F);
    add(1, 1, 4'h1, 32'h1);
    add(0, 1, 4'h2, 32'h12);
    add(0, 1, 4'h3, 32'h123);
    add(0, 1, 4'h4, 32'h1234);
    add(0, 1, 4'h5, 32'h12345);
    add(0, 1, 4'h6, 32'h123456);
    add(0, 1, 4'h7, 32'h1234567);
    add(0, 1, 4'h8, 32'h12345678);
    add(0, 1, 4'h9, 32'h23456789);
    add(1, 0, 4'h1, 32'd1);
    add(0, 0, 4'h2, 32'd12);
    add(0, 0, 4'h3, 32'd123);
    add(0, 0, 4'hA, 32'd123);
    add(0, 0, 4'hC, 32'd0);
    add(0, 0, 4'h0, 32'd0);
    add(0, 0, 4'h9, 32'd9);
    add(0, 0, 4'h9, 32'd99);
    add(0, 0, 4'h9, 32'd999);
    add(0, 0, 4'h9, 32'd9999);
    add(0, 0, 4'h9, 32'd99999);
    add(0, 0, 4'h9, 32'd999999);
    add(0, 0, 4'h9, 32'd9999999);
    add(0, 0, 4'h9, 32'd99999999);
    add(0, 0, 4'h9, 32'd99999999);
    add(0, 1, 4'h1, 32'h5F5E0FF1);
    add(0, 0, 4'h5, 32'h5F5E0FF1);
    add(0, 0, 4'hC, 32'h0);

    // Reset state and idle column scan.
    repeat (3) @(negedge clock);
    chk("rst_col", {28'b0, col}, 32'hE);
    chk("rst_entry", entry_number, 32'h0);
    chk("rst_code", {28'b0, key_code}, 32'h0);
    chk("rst_valid", {31'b0, key_valid}, 32'h0);
    @(negedge clock);
    reset  = 1'b0;
    ecount = 0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      c0 = 4'hF;
      c0[i%4] = 1'b0;
      chk("scan_col", {28'b0, col}, {28'b0, c0});
      repeat (4) @(negedge clock);
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_entry", entry_number, 32'h0);

    // Table of key presses; the first is held 20 ticks.
    foreach (vt[i]) begin
      if (vt[i].clr) begin
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clear", entry_number, 32'h0);
      end
      mode = vt[i].md;
      press(vt[i].code, (i == 0) ? 80 : 16, seen, code, np);
      chk("vec_seen", {31'b0, seen}, 32'h1);
      chk("vec_code", {28'b0, code}, {28'b0, vt[i].code});
      chk("vec_pulses", np, 1);
      chk("vec_entry", entry_number, vt[i].exp);
    end

    // Two-tick row glitch must not be accepted.
    mode = 1'b1;
    p0   = pulses;
    @(negedge clock);
    ovr_row = 4'b1011;
    ovr_en  = 1'b1;
    repeat (8) @(negedge clock);
    ovr_en = 1'b0;
    repeat (40) @(negedge clock);
    chk("glitch_pulses", pulses - p0, 0);
    c0 = col;
    repeat (4) @(negedge clock);
    chk("glitch_scan", {28'b0, col}, {28'b0, c0[2:0], c0[3]});

    // Two rows low together is no key.
    p0 = pulses;
    key_mask[0] = 1'b1;
    key_mask[4] = 1'b1;
    repeat (40) @(negedge clock);
    c0 = col;
    repeat (4) @(negedge clock);
    chk("multi_scan", {28'b0, col}, {28'b0, c0[2:0], c0[3]});
    repeat (40) @(negedge clock);
    key_mask = '0;
    repeat (20) @(negedge clock);
    chk("multi_pulses", pulses - p0, 0);
    chk("multi_entry", entry_number, 32'h0);

    // Reset while the key is held, then re-accept once.
    do_reset();
    mode = 1'b1;
    key_mask[8] = 1'b1;
    wait_valid(seen, code);
    chk("held_seen", {31'b0, seen}, 32'h1);
    chk("held_entry", entry_number, 32'h7);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("hrst_col", {28'b0, col}, 32'hE);
    chk("hrst_entry", entry_number, 32'h0);
    chk("hrst_valid", {31'b0, key_valid}, 32'h0);
    chk("hrst_code", {28'b0, key_code}, 32'h0);
    @(negedge clock);
    reset  = 1'b0;
    ecount = 0;
    p0     = pulses;
    wait_valid(seen, code);
    chk("rehold_seen", {31'b0, seen}, 32'h1);
    chk("rehold_code", {28'b0, code}, 32'h7);
    repeat (60) @(negedge clock);
    chk("rehold_pulses", pulses - p0, 1);
    chk("rehold_entry", entry_number, 32'h7);
    key_mask = '0;
    repeat (40) @(negedge clock);

    // Clear in the accept cycle: accepts land one clock after a tick
    // edge, i.e. on posedges numbered 1 mod 4 since reset release.
    key_mask[5] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (key_valid) begin
        seen = 1'b1;
        chk("race_entry", entry_number, 32'h0);
        chk("race_code", {28'b0, key_code}, 32'h5);
      end
      clear = !seen && (ecount % 4 == 0);
    end
    clear = 1'b0;
    chk("race_seen", {31'b0, seen}, 32'h1);
    key_mask = '0;
    repeat (40) @(negedge clock);
    chk("race_after", entry_number, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry_fsm.md
Name: keypad_entry_fsm

Overview:
- Input-side counterpart to the seven-segment scan driver: scans a 4x4 hex keypad matrix (one column driven low at a time, rows read back) and debounces presses.
- Accumulates accepted key digits into a 32-bit binary number, entry_number, which feeds the display driver's input_number.
- Hex mode shifts in nibbles; decimal mode builds number*10+digit, so the display's binary-to-BCD path shows what was typed.

Parameters:
- SCAN_DIV, 100000: clock cycles per scan tick (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_TICKS, 20: consecutive stable ticks required to accept a press or a release; minimum 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = decimal entry, 1 = hexadecimal entry.
- clear  in  1  synchronous single-cycle clear of entry_number.
- row  in  4  keypad rows, active-low, asynchronous, externally pulled up.
- col  out  4  keypad columns, exactly one bit low at all times.
- entry_number  out  32  accumulated value, binary.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle pulse per accepted press.

Behaviour:
- Reset values: col=4'b1110, entry_number=0, key_code=0, key_valid=0, state=SCAN, tick counter=0, debounce counter=0, column index=0.
- row passes through a 2-flop synchronizer. All sampling uses the synced value.
- Tick: free-running counter 0..SCAN_DIV-1. tick=1 for one cycle when the count is SCAN_DIV-1.
- Key map, (row r, col c) -> code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- "Valid press" means exactly one synced row bit is low. Zero or more than one low bit counts as no key.
- SCAN state:
  - On each tick, if a valid press is present, latch the row index and the current column, set cnt=1, and go to DEBOUNCE.
  - Otherwise advance the column: 0->1->2->3->0, col = ~(1<<idx).
- DEBOUNCE state (column held):
  - On each tick, if the same single row is low, cnt++. Anything else returns to SCAN and advances the column.
  - When cnt reaches DEBOUNCE_TICKS (with DEBOUNCE_TICKS=1, accept at entry), accept the key.
  - Accepting means: on the next clock, key_code=code, key_valid=1 for exactly one cycle, entry_number updates, cnt=0, go to HELD.
- HELD state (column held):
  - On each tick, if row==4'b1111 then cnt++, else cnt=0.
  - When cnt reaches DEBOUNCE_TICKS, go to SCAN and advance the column.
  - Holding a key never repeats it.
- Update rules on accept:
  - Hex mode: entry_number = {entry_number[27:0], code}. The top nibble is discarded, which is the wrap-around.
  - Decimal mode, code 0-9: new = entry_number*10 + code. If new > 99_999_999, entry_number is unchanged.
  - Decimal mode, code C: entry_number=0.
  - Decimal mode, codes A, B, D, E, F: entry_number unchanged.
  - key_valid still pulses in every case above.
- Width rules:
  - The *10 is computed at 36 bits, then compared.
  - A value above 99_999_999 left over from hex mode blocks further decimal digits until a clear.
- mode changes never alter entry_number. The new mode applies from the next accept.
- clear sets entry_number=0 on the next edge. If clear and an accept land in the same cycle, clear wins, but key_code/key_valid still update.
- Reset asserted mid-debounce or mid-hold returns everything to reset values immediately. A key still held after reset is re-debounced and accepted once.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3):
- Reset, no key -> col cycles 1110,1101,1011,0111 every 4 clocks; key_valid stays 0; entry_number=0.
- mode=1, press key at r1/c2 (code 6) for 20 ticks, release -> exactly one key_valid pulse, key_code=6, entry_number=0x6. Press F (r3/c1) -> 0x6F.
- mode=1, enter 9 digits 1..9 -> entry_number=0x23456789 (wrap).
- mode=0, enter 1,2,3 -> entry_number=123. Press C -> 0. Enter 9 x 9 -> stops at 99_999_999; the ninth press pulses key_valid with no value change.
- Row glitch: a low lasting 2 ticks, then high -> no key_valid, returns to scanning. Rows 0 and 1 low together -> ignored.
- clear asserted in the same cycle as an accept -> entry_number=0. Reset asserted during HELD -> col=1110, entry_number=0 immediately.
